// File: rtl/flip_engine.sv
// ============================================================================
// flip_engine
// ----------------------------------------------------------------------------
// Owns the 8x8 Reversi board and resolves one placement request at a time.
// From the target cell it scans the eight directions in a fixed order and
// flips every run of opponent pieces that is bracketed by one of the mover's
// own pieces. If at least one piece was flipped, it places the mover's piece,
// and then pulses next_turn to the downstream turn manager. Otherwise it
// pulses illegal and leaves the board unchanged.
//
// Ports
//   clk           system clock, rising edge
//   resetn        synchronous reset, active HIGH (historical name)
//   initialize    level: clear board and load the four starting pieces
//   whiteOrBlack  current mover from the turn manager (0 black, 1 white)
//   move_valid    one-cycle request strobe, honoured only while idle
//   move_row/col  target cell (row 0 = top, col 0 = left)
//   busy          request in progress
//   next_turn     one-cycle pulse: legal move fully committed
//   illegal       one-cycle pulse: request rejected, board unchanged
//   rd_row/col    display read address
//   rd_cell       combinational cell contents (00 empty, 01 black, 10 white)
//   flip_count    (FLIP_COUNT_EN only) cells flipped by the last request
//
// Build option: define FLIP_COUNT_EN to add the flip_count output.
// ============================================================================
module flip_engine #(
    parameter int BOARD_DIM = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       initialize,
    input  logic       whiteOrBlack,
    input  logic       move_valid,
    input  logic [2:0] move_row,
    input  logic [2:0] move_col,
    output logic       busy,
    output logic       next_turn,
    output logic       illegal,
    input  logic [2:0] rd_row,
    input  logic [2:0] rd_col,
`ifdef FLIP_COUNT_EN
    output logic [5:0] flip_count,
`endif
    output logic [1:0] rd_cell
);

    localparam int CELLS = BOARD_DIM * BOARD_DIM;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CHECK    = 4'd1,
        S_DIR_INIT = 4'd2,
        S_STEP     = 4'd3,
        S_FLIP     = 4'd4,
        S_NEXT_DIR = 4'd5,
        S_PLACE    = 4'd6,
        S_DONE     = 4'd7,
        S_REJECT   = 4'd8
    } state_t;

    // Row delta for direction index: N, NE, E, SE, S, SW, W, NW.
    function automatic logic signed [3:0] delta_row(input logic [2:0] dir);
        case (dir)
            3'd0, 3'd1, 3'd7: delta_row = -4'sd1;
            3'd3, 3'd4, 3'd5: delta_row = 4'sd1;
            default:          delta_row = 4'sd0;
        endcase
    endfunction

    // Column delta for direction index: N, NE, E, SE, S, SW, W, NW.
    function automatic logic signed [3:0] delta_col(input logic [2:0] dir);
        case (dir)
            3'd1, 3'd2, 3'd3: delta_col = 4'sd1;
            3'd5, 3'd6, 3'd7: delta_col = -4'sd1;
            default:          delta_col = 4'sd0;
        endcase
    endfunction

    // A 4-bit signed cursor only ever moves by +/-1 from 0..7, so stepping past
    // 7 wraps to -8: "outside 0..7" reduces to "negative".
    function automatic logic on_board(input logic signed [3:0] r,
                                      input logic signed [3:0] c);
        on_board = (r >= 4'sd0) && (c >= 4'sd0);
    endfunction

    // Starting position: white on (3,3)/(4,4), black on (3,4)/(4,3).
    function automatic logic [1:0] init_cell(input logic [5:0] idx);
        case (idx)
            6'd27, 6'd36: init_cell = 2'b10;
            6'd28, 6'd35: init_cell = 2'b01;
            default:      init_cell = 2'b00;
        endcase
    endfunction

    state_t             state_r, next_state_s;
    logic [1:0]         board_r [0:CELLS-1];
    logic [2:0]         row_r, col_r, dir_r, run_r;
    logic               player_r, any_flip_r;
    logic signed [3:0]  cur_row_r, cur_col_r;
    logic signed [3:0]  drow_s, dcol_s;
    logic signed [3:0]  init_row_s, init_col_s, step_row_s, step_col_s;
    logic signed [3:0]  back_row_s, back_col_s;
    logic [1:0]         own_s, cell_s, target_cell_s;
    logic               wr_en_s, busy_s, next_turn_s, illegal_s;
    logic [5:0]         wr_idx_s;
    logic               busy_r, next_turn_r, illegal_r;

    assign own_s         = player_r ? 2'b10 : 2'b01;
    assign drow_s        = delta_row(dir_r);
    assign dcol_s        = delta_col(dir_r);
    assign init_row_s    = $signed({1'b0, row_r}) + drow_s;
    assign init_col_s    = $signed({1'b0, col_r}) + dcol_s;
    assign step_row_s    = cur_row_r + drow_s;
    assign step_col_s    = cur_col_r + dcol_s;
    assign back_row_s    = cur_row_r - drow_s;
    assign back_col_s    = cur_col_r - dcol_s;
    assign cell_s        = board_r[{cur_row_r[2:0], cur_col_r[2:0]}];
    assign target_cell_s = board_r[{row_r, col_r}];
    assign rd_cell       = board_r[{rd_row, rd_col}];
    assign busy          = busy_r;
    assign next_turn     = next_turn_r;
    assign illegal       = illegal_r;

    // State register plus registered status outputs decoded from next state.
    always_ff @(posedge clk) begin
        if (resetn || initialize) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            next_turn_r <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            busy_r      <= busy_s;
            next_turn_r <= next_turn_s;
            illegal_r   <= illegal_s;
        end
    end

    // Next-state logic of the scan sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (move_valid) next_state_s = S_CHECK;
                else            next_state_s = S_IDLE;
            end
            S_CHECK: begin
                if (target_cell_s != 2'b00) next_state_s = S_REJECT;
                else                        next_state_s = S_DIR_INIT;
            end
            S_DIR_INIT: begin
                if (on_board(init_row_s, init_col_s)) next_state_s = S_STEP;
                else                                  next_state_s = S_NEXT_DIR;
            end
            S_STEP: begin
                if (cell_s == 2'b00) begin
                    next_state_s = S_NEXT_DIR;
                end else if (cell_s == own_s) begin
                    if (run_r == 3'd0) next_state_s = S_NEXT_DIR;
                    else               next_state_s = S_FLIP;
                end else if (on_board(step_row_s, step_col_s)) begin
                    next_state_s = S_STEP;
                end else begin
                    next_state_s = S_NEXT_DIR;
                end
            end
            S_FLIP: begin
                if (run_r == 3'd1) next_state_s = S_NEXT_DIR;
                else               next_state_s = S_FLIP;
            end
            S_NEXT_DIR: begin
                if (dir_r != 3'd7)   next_state_s = S_DIR_INIT;
                else if (any_flip_r) next_state_s = S_PLACE;
                else                 next_state_s = S_REJECT;
            end
            S_PLACE:  next_state_s = S_DONE;
            S_DONE:   next_state_s = S_IDLE;
            S_REJECT: next_state_s = S_IDLE;
            default:  next_state_s = S_IDLE;
        endcase
    end

    // Output decode: board write port and status for the next cycle.
    always_comb begin
        wr_en_s  = 1'b0;
        wr_idx_s = {row_r, col_r};
        case (state_r)
            S_FLIP: begin
                // Step back toward the target and recolour that cell.
                wr_en_s  = on_board(back_row_s, back_col_s);
                wr_idx_s = {back_row_s[2:0], back_col_s[2:0]};
            end
            S_PLACE: begin
                wr_en_s  = 1'b1;
                wr_idx_s = {row_r, col_r};
            end
            default: begin
                wr_en_s  = 1'b0;
                wr_idx_s = {row_r, col_r};
            end
        endcase
        busy_s      = (next_state_s != S_IDLE) && (next_state_s != S_DONE) &&
                      (next_state_s != S_REJECT);
        next_turn_s = (next_state_s == S_DONE);
        illegal_s   = (next_state_s == S_REJECT);
    end

    // Request latch, direction index, cursor and run length.
    always_ff @(posedge clk) begin
        if (resetn || initialize) begin
            row_r      <= 3'd0;
            col_r      <= 3'd0;
            player_r   <= 1'b0;
            dir_r      <= 3'd0;
            run_r      <= 3'd0;
            any_flip_r <= 1'b0;
            cur_row_r  <= 4'sd0;
            cur_col_r  <= 4'sd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (move_valid) begin
                        row_r    <= move_row;
                        col_r    <= move_col;
                        player_r <= whiteOrBlack;
                    end
                end
                S_CHECK: begin
                    any_flip_r <= 1'b0;
                    dir_r      <= 3'd0;
                end
                S_DIR_INIT: begin
                    cur_row_r <= init_row_s;
                    cur_col_r <= init_col_s;
                    run_r     <= 3'd0;
                end
                S_STEP: begin
                    // Only an opponent piece extends the run.
                    if ((cell_s != 2'b00) && (cell_s != own_s)) begin
                        run_r     <= run_r + 3'd1;
                        cur_row_r <= step_row_s;
                        cur_col_r <= step_col_s;
                    end
                end
                S_FLIP: begin
                    cur_row_r <= back_row_s;
                    cur_col_r <= back_col_s;
                    run_r     <= run_r - 3'd1;
                    if (run_r == 3'd1) any_flip_r <= 1'b1;
                end
                S_NEXT_DIR: dir_r <= dir_r + 3'd1;
                default: begin
                end
            endcase
        end
    end

    // Board storage: reset clears, initialize loads the opening, else one write.
    always_ff @(posedge clk) begin
        if (resetn) begin
            for (int i = 0; i < CELLS; i++) board_r[i] <= 2'b00;
        end else if (initialize) begin
            for (int i = 0; i < CELLS; i++) board_r[i] <= init_cell(6'(i));
        end else if (wr_en_s) begin
            board_r[wr_idx_s] <= own_s;
        end
    end

`ifdef FLIP_COUNT_EN
    logic [5:0] flip_count_r;
    assign flip_count = flip_count_r;

    // Flip counter: cleared on accept, one count per recoloured cell.
    always_ff @(posedge clk) begin
        if (resetn || initialize) begin
            flip_count_r <= 6'd0;
        end else if ((state_r == S_IDLE) && move_valid) begin
            flip_count_r <= 6'd0;
        end else if (state_r == S_FLIP) begin
            flip_count_r <= flip_count_r + 6'd1;
        end
    end
`endif

endmodule

// File: tb/tb_flip_engine.sv
module tb_flip_engine;

    logic       clk = 1'b0;
    logic       resetn, initialize, whiteOrBlack, move_valid;
    logic [2:0] move_row, move_col, rd_row, rd_col;
    logic       busy, next_turn, illegal;
    logic [1:0] rd_cell;
`ifdef FLIP_COUNT_EN
    logic [5:0] flip_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_ovl = 0;
    logic [1:0] exp_b [0:63];

    always #5 clk = ~clk;

    flip_engine dut (
        .clk          (clk),
        .resetn       (resetn),
        .initialize   (initialize),
        .whiteOrBlack (whiteOrBlack),
        .move_valid   (move_valid),
        .move_row     (move_row),
        .move_col     (move_col),
        .busy         (busy),
        .next_turn    (next_turn),
        .illegal      (illegal),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
`ifdef FLIP_COUNT_EN
        .flip_count   (flip_count),
`endif
        .rd_cell      (rd_cell)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) exp_b[i] = 2'b00;
    endtask

    task automatic model_init();
        model_clear();
        exp_b[27] = 2'b10;
        exp_b[36] = 2'b10;
        exp_b[28] = 2'b01;
        exp_b[35] = 2'b01;
    endtask

    // Read every cell through the display port, one cell per cycle.
    task automatic compare_board(input string tag);
        for (int i = 0; i < 64; i++) begin
            rd_row = 3'(i / 8);
            rd_col = 3'(i % 8);
            @(negedge clk);
            check($sformatf("%s_r%0dc%0d", tag, i / 8, i % 8), {30'd0, rd_cell}, {30'd0, exp_b[i]});
        end
    endtask

    task automatic do_init();
        initialize = 1'b1;
        @(negedge clk);
        initialize = 1'b0;
        model_init();
    endtask

    // Issue one request; optionally hold move_valid one more cycle (while
    // busy) with a different, otherwise-legal target. Count response pulses
    // over a fixed window.
    task automatic run_move(input logic [2:0] r, input logic [2:0] c, input logic pl,
                            input bit dup, output int nt, output int il, output int first);
        nt = 0;
        il = 0;
        first = -1;
        move_row = r;
        move_col = c;
        whiteOrBlack = pl;
        move_valid = 1'b1;
        @(negedge clk);
        if (dup) begin
            move_row = 3'd2;
            move_col = 3'd3;
        end else begin
            move_valid = 1'b0;
        end
        for (int i = 0; i < 120; i++) begin
            if (i == 0) check("busy_after_accept", {31'd0, busy}, 32'd1);
            if (next_turn) begin
                nt++;
                if (first < 0) first = i;
            end
            if (illegal) begin
                il++;
                if (first < 0) first = i;
            end
            if ((next_turn && illegal) || ((next_turn || illegal) && busy)) n_ovl++;
            @(negedge clk);
            move_valid = 1'b0;
        end
    endtask

    initial begin
        int nt, il, first;
        resetn = 1'b1;
        initialize = 1'b0;
        whiteOrBlack = 1'b0;
        move_valid = 1'b0;
        move_row = 3'd0;
        move_col = 3'd0;
        rd_row = 3'd0;
        rd_col = 3'd0;
        @(negedge clk);
        resetn = 1'b0;

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_next_turn", {31'd0, next_turn}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        model_clear();
        compare_board("rst");

        // Opening position
        do_init();
        check("init_busy", {31'd0, busy}, 32'd0);
        compare_board("init");

        // Black (2,3): flips (3,3) via the S direction.
        run_move(3'd2, 3'd3, 1'b0, 1'b0, nt, il, first);
        check("b23_next_turn_cnt", nt, 32'd1);
        check("b23_illegal_cnt", il, 32'd0);
        check("b23_latency_ok", {31'd0, (first >= 0) && (first < 100)}, 32'd1);
        check("b23_idle", {31'd0, busy}, 32'd0);
`ifdef FLIP_COUNT_EN
        check("b23_flip_count", {26'd0, flip_count}, 32'd1);
`endif
        exp_b[27] = 2'b01;
        exp_b[19] = 2'b01;
        compare_board("b23");

        // White (2,2): flips (3,3) back via SE, bracketed by (4,4).
        run_move(3'd2, 3'd2, 1'b1, 1'b0, nt, il, first);
        check("w22_next_turn_cnt", nt, 32'd1);
        check("w22_illegal_cnt", il, 32'd0);
`ifdef FLIP_COUNT_EN
        check("w22_flip_count", {26'd0, flip_count}, 32'd1);
`endif
        exp_b[27] = 2'b10;
        exp_b[18] = 2'b10;
        compare_board("w22");

        // Black (0,0) from the opening: nothing bracketed, corner edges.
        do_init();
        run_move(3'd0, 3'd0, 1'b0, 1'b0, nt, il, first);
        check("c00_illegal_cnt", il, 32'd1);
        check("c00_next_turn_cnt", nt, 32'd0);
`ifdef FLIP_COUNT_EN
        check("c00_flip_count", {26'd0, flip_count}, 32'd0);
`endif
        compare_board("c00");

        // Occupied (3,3) with a second strobe while busy: one response only.
        run_move(3'd3, 3'd3, 1'b0, 1'b1, nt, il, first);
        check("occ_illegal_cnt", il, 32'd1);
        check("occ_next_turn_cnt", nt, 32'd0);
        compare_board("occ");

        // Reset in the middle of a legal scan.
        move_row = 3'd2;
        move_col = 3'd3;
        whiteOrBlack = 1'b0;
        move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_next_turn", {31'd0, next_turn}, 32'd0);
        rd_row = 3'd3;
        rd_col = 3'd3;
        #1;
        check("abort_cell33", {30'd0, rd_cell}, 32'd0);
        nt = 0;
        il = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (next_turn) nt++;
            if (illegal) il++;
        end
        check("abort_no_next_turn", nt, 32'd0);
        check("abort_no_illegal", il, 32'd0);
        model_clear();
        compare_board("abort");

        check("pulse_exclusive", n_ovl, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
